// File: rtl/shape_processor_mc_if.sv
// Register bus between the bus bridge and the shape processor.
// The bridge drives strobes, address and write data; the SFR block returns read data and flags.
interface shape_processor_mc_if #(
    parameter int ADDR_W = 3
);
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       write_data;
    logic [31:0]       read_data;
    logic              read_valid;
    logic              error;

    modport master (
        output write, read, addr, write_data,
        input  read_data, read_valid, error
    );

    modport slave (
        input  write, read, addr, write_data,
        output read_data, read_valid, error
    );
endinterface

// File: rtl/shape_processor_mc.sv
// Multi-channel shape/operation CTRL SFRs with shared STATUS (sticky errors + error counter).
// CTRL registers only ever hold legal shape/operation pairs; illegal writes are rejected.
module shape_processor_mc #(
    parameter int NUM_CHANNELS = 4,
    parameter bit STRICT       = 1'b1,
    parameter int CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    shape_processor_mc_if.slave  bus
);
    localparam int ADDR_W = $clog2(NUM_CHANNELS + 1);
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [3:0]              shape_q [NUM_CHANNELS];
    logic [3:0]              shape_d [NUM_CHANNELS];
    logic [3:0]              op_q    [NUM_CHANNELS];
    logic [3:0]              op_d    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    err_q, err_d;

    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic              is_ctrl, is_status;
    logic [CH_W-1:0]   ch;
    logic [3:0]        cur_s, cur_o, ws, wo, eff_s, eff_o;
    logic              rsv, shape_ok, op_ok, combo_ok, legal;
    logic [31:0]       rd_mux;

    assign addr      = bus.addr;
    assign wd        = bus.write_data;
    assign is_ctrl   = addr < ADDR_W'(NUM_CHANNELS);
    assign is_status = addr == ADDR_W'(NUM_CHANNELS);
    assign ch        = is_ctrl ? CH_W'(addr) : '0;

    assign cur_s = shape_q[ch];
    assign cur_o = op_q[ch];
    assign ws    = wd[3:0];
    assign wo    = wd[11:8];
    assign rsv   = |{wd[31:12], wd[7:4]};

    // KEEP (0) takes the channel's current value before the combo check
    assign eff_s = (ws == 4'd0) ? cur_s : ws;
    assign eff_o = (wo == 4'd0) ? cur_o : wo;

    assign shape_ok = ws <= 4'd3;
    assign op_ok    = wo <= 4'd5;

    always_comb begin
        combo_ok = 1'b0;
        unique case (eff_o)
            4'd1, 4'd2: combo_ok = eff_s inside {4'd1, 4'd2, 4'd3};
            4'd3:       combo_ok = eff_s == 4'd2;
            4'd4, 4'd5: combo_ok = eff_s == 4'd3;
            default:    combo_ok = 1'b0;
        endcase
    end

    assign legal = shape_ok && op_ok && combo_ok && (!STRICT || !rsv);

    always_comb begin
        rd_mux = '0;
        if (is_ctrl) begin
            rd_mux = {20'd0, cur_o, 4'd0, cur_s};
        end else if (is_status) begin
            rd_mux = {16'(cnt_q), 16'(sticky_q)};
        end
    end

    always_comb begin
        shape_d  = shape_q;
        op_d     = op_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        rvalid_d = bus.read;
        rdata_d  = bus.read ? rd_mux : rdata_q;
        if (bus.write) begin
            unique case (1'b1)
                is_ctrl && legal: begin
                    shape_d[ch] = eff_s;
                    op_d[ch]    = eff_o;
                end
                is_status: begin
                    sticky_d = sticky_q & ~wd[NUM_CHANNELS-1:0];
                    if (wd[31]) cnt_d = '0;
                end
                default: begin
                    err_d = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    if (is_ctrl) sticky_d[ch] = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shape_q[i] <= 4'd1;
                op_q[i]    <= 4'd1;
            end
            sticky_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shape_q  <= shape_d;
            op_q     <= op_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign bus.read_data  = rdata_q;
    assign bus.read_valid = rvalid_q;
    assign bus.error      = err_q;
endmodule
